// File: rtl/int_to_float.sv
// int_to_float: two-stage elastic signed-integer to {s,e,f} float converter (truncating)
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_data/in_valid      signed integer sample and its valid
//   in_ready              stage 1 can take a sample this cycle
//   out_data/out_valid    registered {sign, exponent, fraction} and its valid
//   out_ready             downstream consumes out_data this cycle
module int_to_float #(
    parameter int              I_bit = 32,
    parameter int              E_bit = 8,
    parameter int              F_bit = 23,
    parameter logic [E_bit-1:0] E_ref = {(E_bit-1){1'b1}},
    parameter logic [E_bit-1:0] E_max = {E_bit{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [I_bit-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [E_bit+F_bit:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int PW = $clog2(I_bit);

    // Bits of the encoder mask for output bit b: positions whose index has bit b set.
    function automatic logic [I_bit-1:0] f_mask(input int b);
        logic [I_bit-1:0] m;
        m = '0;
        for (int i = 0; i < I_bit; i++) m[i] = ((i >> b) & 1) == 1;
        return m;
    endfunction

    logic                 r_s1_valid;
    logic                 r_s1_sign;
    logic                 r_s1_zero;
    logic [I_bit-1:0]     r_s1_mag;
    logic                 r_s2_valid;
    logic [E_bit+F_bit:0] r_s2_data;

    logic                 w_s1_adv;
    logic                 w_s2_adv;
    logic [I_bit-1:0]     w_mag;
    logic [I_bit-1:0]     w_lead;
    logic [PW-1:0]        w_p;
    logic [PW-1:0]        w_sh;
    logic [F_bit-1:0]     w_frac;
    logic [E_bit:0]       w_exp;
    logic [E_bit+F_bit:0] w_pack;

    assign w_s2_adv  = !r_s2_valid | out_ready;
    assign w_s1_adv  = !r_s1_valid | w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;

    // Negation in I_bit unsigned bits maps the most negative value onto 2^(I_bit-1).
    assign w_mag = in_data[I_bit-1] ? -in_data : in_data;

    // One-hot leading-one detect, then OR-encode the one-hot into its index.
    for (genvar i = 0; i < I_bit; i++) begin : g_lead
        if (i == I_bit - 1) begin : g_top
            assign w_lead[i] = r_s1_mag[i];
        end else begin : g_low
            assign w_lead[i] = r_s1_mag[i] & ~|r_s1_mag[I_bit-1:i+1];
        end
    end

    for (genvar b = 0; b < PW; b++) begin : g_enc
        localparam logic [I_bit-1:0] M = f_mask(b);
        assign w_p[b] = |(w_lead & M);
    end

    assign w_sh = PW'(I_bit - 1) - w_p;

    // After normalising, the leading one sits at bit I_bit-1 and is implicit.
    if (I_bit - 1 >= F_bit) begin : g_trunc
        assign w_frac = F_bit'((r_s1_mag << w_sh) >> (I_bit - 1 - F_bit));
    end else begin : g_pad
        assign w_frac = {(I_bit-1)'(r_s1_mag << w_sh), {(F_bit-I_bit+1){1'b0}}};
    end

    assign w_exp  = {1'b0, E_ref} + (E_bit+1)'(w_p);
    assign w_pack = r_s1_zero ? '0 :
                    (w_exp >= {1'b0, E_max}) ? {r_s1_sign, E_max, {F_bit{1'b0}}} :
                    {r_s1_sign, w_exp[E_bit-1:0], w_frac};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_mag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                r_s2_data  <= w_pack;
            end
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                r_s1_sign  <= in_data[I_bit-1];
                r_s1_zero  <= in_data == '0;
                r_s1_mag   <= w_mag;
            end
        end
    end
endmodule

// File: tb/tb_int_to_float.sv
// tb_int_to_float: directed and random checks of int_to_float at default parameters
module tb_int_to_float;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] q[$];

    int_to_float dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_conv(input logic [31:0] x);
        logic [31:0] m;
        logic [22:0] f;
        int p;
        if (x == 0) return 32'h0;
        m = x[31] ? (~x + 32'd1) : x;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        f = (p >= 23) ? 23'(m >> (p - 23)) : 23'(m << (23 - p));
        return {x[31], 8'(127 + p), f};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'd5;
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset got valid=%b data=%h ready=%b exp 0/00000000/1", out_valid, out_data, in_ready);
        end
        tick();
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ignore got valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_values();
        logic [31:0] vi [0:12];
        logic [31:0] ve [0:12];
        vi = '{32'd1, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'h7FFFFFFF, 32'd16777217,
               32'd2, 32'hFFFFFFFE, 32'd10, 32'd255, 32'd3, 32'd5, 32'd7};
        ve = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'hCF000000, 32'h4EFFFFFF, 32'h4B800000,
               32'h40000000, 32'hC0000000, 32'h41200000, 32'h437F0000, 32'h40400000, 32'h40A00000, 32'h40E00000};
        out_ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            in_valid = 1'b1;
            in_data = vi[k];
            #1;
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL value_ready[%0d] got=%b exp=1", k, in_ready);
            end
            tick();
            in_valid = 1'b0;
            #1;
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL value_early[%0d] got valid=%b exp 0", k, out_valid);
            end
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== ve[k]) begin
                n_err++;
                $display("FAIL value[%0d] in=%h got valid=%b data=%h exp 1/%h", k, vi[k], out_valid, out_data, ve[k]);
            end
            tick();
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL value_drain[%0d] got valid=%b exp 0", k, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ev;
        q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 1004; k++) begin
            in_valid = k < 1000;
            in_data = $urandom;
            #1;
            if (in_valid && in_ready) q.push_back(ref_conv(in_data));
            ev = (k >= 2) && (k < 1002);
            n_vec++;
            if (out_valid !== ev) begin
                n_err++;
                $display("FAIL stream_valid[%0d] got=%b exp=%b", k, out_valid, ev);
            end
            if (out_valid === 1'b1) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_extra[%0d] got data=%h exp no output", k, out_data);
                end else if (out_data !== q[0]) begin
                    n_err++;
                    $display("FAIL stream_data[%0d] got=%h exp=%h", k, out_data, q[0]);
                    void'(q.pop_front());
                end else begin
                    void'(q.pop_front());
                end
            end
            tick();
        end
        in_valid = 1'b0;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL stream_lost got %0d pending exp 0", q.size());
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'd3;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept3 got=%b exp=1", in_ready); end
        tick();
        in_data = 32'd5;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept5 got=%b exp=1", in_ready); end
        tick();
        in_data = 32'd7;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h40400000) begin
                n_err++;
                $display("FAIL bp_stall[%0d] got ready=%b valid=%b data=%h exp 0/1/40400000", k, in_ready, out_valid, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_data !== 32'h40400000) begin
            n_err++;
            $display("FAIL bp_release got ready=%b data=%h exp 1/40400000", in_ready, out_data);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h40A00000) begin
            n_err++;
            $display("FAIL bp_out5 got valid=%b data=%h exp 1/40A00000", out_valid, out_data);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h40E00000) begin
            n_err++;
            $display("FAIL bp_out7 got valid=%b data=%h exp 1/40E00000", out_valid, out_data);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got valid=%b exp 0", out_valid); end
    endtask

    task automatic test_random_handshake();
        logic        hold = 1'b0;
        logic [31:0] hd = '0;
        q.delete();
        for (int k = 0; k < 640; k++) begin
            in_valid = (k < 600) ? 1'($urandom % 2) : 1'b0;
            in_data = (k % 3 == 0) ? 32'($urandom % 64) - 32'd32 : $urandom;
            out_ready = (k < 600) ? 1'($urandom % 2) : 1'b1;
            #1;
            if (hold) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== hd) begin
                    n_err++;
                    $display("FAIL rand_stable[%0d] got valid=%b data=%h exp 1/%h", k, out_valid, out_data, hd);
                end
            end
            if (in_valid && in_ready) q.push_back(ref_conv(in_data));
            if (out_valid === 1'b1 && out_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra[%0d] got data=%h exp no output", k, out_data);
                end else begin
                    if (out_data !== q[0]) begin
                        n_err++;
                        $display("FAIL rand_data[%0d] got=%h exp=%h", k, out_data, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            hold = (out_valid === 1'b1) && !out_ready;
            hd = out_data;
            tick();
        end
        n_vec++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rand_lost got pending=%0d valid=%b exp 0/0", q.size(), out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'd100;
        tick();
        in_data = 32'd200;
        tick();
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_full got ready=%b valid=%b exp 0/1", in_ready, out_valid);
        end
        rst = 1'b1;
        in_data = 32'd300;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset got valid=%b data=%h ready=%b exp 0/00000000/1", out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL mid_discard[%0d] got valid=%b data=%h exp 0", k, out_valid, out_data);
            end
        end
        in_valid = 1'b1;
        in_data = 32'd9;
        tick();
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_early got valid=%b exp 0", out_valid); end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h41100000) begin
            n_err++;
            $display("FAIL mid_first got valid=%b data=%h exp 1/41100000", out_valid, out_data);
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        test_reset();
        test_values();
        test_back_to_back();
        test_backpressure();
        test_random_handshake();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/int_to_float.md
# int_to_float

Pipelined signed-integer to floating-point converter. It sits directly upstream of the float adder and turns two's-complement fixed-point samples (ADC or counter values) into the same `{s, e, f}` float format the adder consumes. It uses a two-stage elastic valid/ready pipeline that sustains one conversion per clock and applies truncation (round-toward-zero), matching the adder's truncating normalisation.

## Interface
Parameters:
- `I_bit`, 32, input integer width (two's complement), ≥ 2
- `E_bit`, 8, exponent width of output float
- `F_bit`, 23, fraction width of output float
- `E_ref`, `{(E_bit-1){1'b1}}`, exponent bias (derived; not normally overridden)
- `E_max`, `{E_bit{1'b1}}`, all-ones exponent (derived)

Ports:
- `clk` input 1: single clock; all state on rising edge
- `rst` input 1: reset, synchronous, active-high
- `in_data` input I_bit: signed integer sample
- `in_valid` input 1: `in_data` is valid this cycle
- `in_ready` output 1: block accepts `in_data` this cycle
- `out_data` output E_bit+F_bit+1: `{sign, exponent, fraction}`
- `out_valid` output 1: `out_data` is valid
- `out_ready` input 1: downstream (adder operand feeder) consumes `out_data` this cycle

## Operation
- Transfer on an interface occurs when valid and ready are both high in the same cycle.
- Stage 1 (capture):
  - sign = `in_data[I_bit-1]`
  - mag = sign ? -in_data : in_data, held as an I_bit-bit unsigned value (so −2^(I_bit-1) yields magnitude 2^(I_bit-1) with no overflow)
  - zero = (in_data == 0)
- Stage 2 (normalise, pack):
  - p = index of the most-significant 1 in mag (0..I_bit-1), via a parallel priority encoder, not a serial loop.
  - Left-shift mag by (I_bit-1-p) so the leading one lands at bit I_bit-1.
  - Fraction = the next F_bit bits below the leading one. Pad with zeros if fewer than F_bit bits are available; otherwise drop the lower bits (truncate).
  - Exponent = E_ref + p, computed in E_bit+1 bits.
  - If the exponent is ≥ E_max, output `{sign, E_max, 0}` (signed infinity). This is unreachable at default parameters.
  - zero = 1 → `out_data` = all zeros (+0.0; −0 is never produced).
- Pipeline control: each stage has its own valid flag.
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - `in_ready` = s1_adv. This is a combinational path from `out_ready`, and that path is accepted.
  - Stage 2 loads from stage 1 when s2_adv. Its valid becomes s1_valid, so a bubble propagates as invalid.
  - Stage 1 loads when s1_adv. Its valid becomes in_valid.
  - A stalled stage holds its data and valid unchanged. `out_data` is stable while `out_valid` is high and `out_ready` is low.
- `out_valid` = s2_valid; `out_data` = stage-2 register (registered output, no combinational path from input).

## Timing
- Latency: sample accepted at edge N appears on `out_data`/`out_valid` after edge N+1 (two register stages) when unstalled.
- Throughput: one sample per clock with `out_ready` held high; no bubbles inserted.
- Capacity: 2 samples. With `out_ready` low, at most 2 are accepted, and then `in_ready` drops in the same cycle the second is accepted plus one.
- Simultaneous accept and consume when full: the pipeline shifts; `in_ready` stays high.
- Reset (any cycle, including mid-stream): at the next edge both valid flags and all data registers clear. `out_valid` = 0, `out_data` = 0. `in_ready` reads 1 once out of reset. In-flight samples are discarded, not flushed.
- While `rst` is high, `in_valid` is ignored and no transfer is counted.

## Test plan
- Basic values, `out_ready`=1: 1 → 0x3F800000; −1 (0xFFFFFFFF) → 0xBF800000; 0 → 0x00000000; each appears 2 cycles after accept.
- Extremes: 0x80000000 → 0xCF000000; 0x7FFFFFFF → 0x4EFFFFFF (truncated, not rounded to 0x4F000000); 16777217 → 0x4B800000.
- Streaming: 1000 random back-to-back samples with `in_valid`=1 and `out_ready`=1 → one output per cycle, in order, bit-exact against a truncating reference model.
- Backpressure: `out_ready`=0; offer 3, 5, 7 on consecutive cycles → only 3 and 5 accepted, `in_ready`=0 while 7 is held. Raise `out_ready` → outputs 0x40400000, 0x40A00000, 0x40E00000 in order, `out_data` stable during the stall.
- Random `in_valid`/`out_ready` toggling (50% each) → no loss, duplication or reordering; `out_data` never changes while `out_valid` & !`out_ready`.
- Reset mid-stream: assert `rst` for 1 cycle with both stages full → next cycle `out_valid`=0, `out_data`=0; the first post-reset sample converts correctly with 2-cycle latency.
